// File: rtl/fm_ddr_in_sync.sv
// Embedded-sync receiver for the demultiplexed DDR video input: decodes FF 00 00 XY
// timing codes on Y, regenerates DE/HS/VS/field, pixel/line counters and lock status.
module fm_ddr_in_sync #(
  parameter int LOCK_LINES = 4,
  parameter int TIMEOUT    = 4400
) (
  input  logic        clk_v,
  input  logic        rst_x,
  input  logic [7:0]  i_y,
  input  logic [7:0]  i_c,
  output logic [7:0]  o_y,
  output logic [7:0]  o_c,
  output logic        o_de,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_field,
  output logic [11:0] o_pix_cnt,
  output logic [10:0] o_line_cnt,
  output logic        o_err,
  output logic        o_locked
);

  // Protection nibble carried in the low bits of a TRS XY word.
  function automatic logic [3:0] trs_prot(input logic f, input logic v, input logic h);
    return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  logic [3:0][7:0] y_r;
  logic [3:0][7:0] c_r;
  logic [3:0]      de_r;
  logic [3:0]      h_r;
  logic [3:0]      xy_r;
  logic            active_r;
  logic            hblank_r;
  logic [2:0]      lock_cnt_r;
  logic [12:0]     wd_r;

  logic            trs_s;
  logic            valid_s;
  logic            perr_s;
  logic            eav_s;
  logic            sav_s;
  logic            active_nxt_s;
  logic            hblank_nxt_s;
  logic            out_de_s;
  logic            out_h_s;
  logic [3:0]      de_nxt_s;
  logic [3:0]      h_nxt_s;
  logic [3:0]      xy_nxt_s;

  // TRS pattern detection and protection check on the four Y stages.
  always_comb begin
    trs_s   = (y_r[3] == 8'hFF) && (y_r[2] == 8'h00) && (y_r[1] == 8'h00) && y_r[0][7];
    valid_s = trs_s && (y_r[0][3:0] == trs_prot(y_r[0][6], y_r[0][5], y_r[0][4]));
    perr_s  = trs_s && !valid_s;
    eav_s   = valid_s && y_r[0][4];
    sav_s   = valid_s && !y_r[0][4];
  end

  // Next flag values and stage tags; TRS words are forced out of the active region.
  always_comb begin
    active_nxt_s = active_r;
    hblank_nxt_s = hblank_r;
    if (eav_s) begin
      active_nxt_s = 1'b0;
      hblank_nxt_s = 1'b1;
    end else if (sav_s) begin
      active_nxt_s = active_r | ~y_r[0][5];
      hblank_nxt_s = 1'b0;
    end else begin
      active_nxt_s = active_r;
      hblank_nxt_s = hblank_r;
    end

    // The entering word already sees the flags as updated by the code now in s0.
    de_nxt_s = {de_r[2:0], active_nxt_s};
    h_nxt_s  = {h_r[2:0], hblank_nxt_s};
    xy_nxt_s = {xy_r[2:0], 1'b0};
    out_de_s = de_r[3];
    out_h_s  = h_r[3];
    if (valid_s) begin
      de_nxt_s[3:1] = 3'b000;
      out_de_s      = 1'b0;
      xy_nxt_s[1]   = 1'b1;
      if (eav_s) begin
        h_nxt_s[3:1] = 3'b111;
        out_h_s      = 1'b1;
      end else begin
        h_nxt_s[3:1] = h_r[2:0];
        out_h_s      = h_r[3];
      end
    end else begin
      out_de_s = de_r[3];
      out_h_s  = h_r[3];
    end
  end

  // Four-stage Y/C pipeline with tags, plus the region flags.
  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      y_r      <= '0;
      c_r      <= '0;
      de_r     <= 4'b0000;
      h_r      <= 4'b0000;
      xy_r     <= 4'b0000;
      active_r <= 1'b0;
      hblank_r <= 1'b0;
    end else begin
      y_r      <= {y_r[2:0], i_y};
      c_r      <= {c_r[2:0], i_c};
      de_r     <= de_nxt_s;
      h_r      <= h_nxt_s;
      xy_r     <= xy_nxt_s;
      active_r <= active_nxt_s;
      hblank_r <= hblank_nxt_s;
    end
  end

  // Output register stage: data, timing, V/F and counters aligned to o_y.
  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      o_y        <= 8'h00;
      o_c        <= 8'h00;
      o_de       <= 1'b0;
      o_hs       <= 1'b0;
      o_vs       <= 1'b0;
      o_field    <= 1'b0;
      o_pix_cnt  <= 12'd0;
      o_line_cnt <= 11'd0;
      o_err      <= 1'b0;
    end else begin
      o_y   <= y_r[3];
      o_c   <= c_r[3];
      o_de  <= out_de_s;
      o_hs  <= out_h_s;
      o_err <= perr_s;
      if (xy_r[3]) begin
        o_vs    <= y_r[3][5];
        o_field <= y_r[3][6];
        // A V=0 EAV right after vertical blanking starts a new active field.
        if (y_r[3][4]) begin
          if (!y_r[3][5] && o_vs) begin
            o_line_cnt <= 11'd0;
          end else begin
            o_line_cnt <= o_line_cnt + 11'd1;
          end
        end else begin
          o_line_cnt <= o_line_cnt;
        end
      end else begin
        o_vs    <= o_vs;
        o_field <= o_field;
      end
      if (out_de_s) begin
        if (!o_de) begin
          o_pix_cnt <= 12'd0;
        end else if (o_pix_cnt == 12'hFFF) begin
          o_pix_cnt <= 12'hFFF;
        end else begin
          o_pix_cnt <= o_pix_cnt + 12'd1;
        end
      end else begin
        o_pix_cnt <= o_pix_cnt;
      end
    end
  end

  // Lock qualification on consecutive good EAVs, dropped on errors or EAV starvation.
  always_ff @(posedge clk_v or negedge rst_x) begin
    if (!rst_x) begin
      lock_cnt_r <= 3'd0;
      wd_r       <= 13'd0;
      o_locked   <= 1'b0;
    end else if (eav_s) begin
      wd_r <= 13'd0;
      if (lock_cnt_r >= 3'(LOCK_LINES - 1)) begin
        lock_cnt_r <= 3'(LOCK_LINES);
        o_locked   <= 1'b1;
      end else begin
        lock_cnt_r <= lock_cnt_r + 3'd1;
        o_locked   <= o_locked;
      end
    end else if (perr_s || (wd_r == 13'(TIMEOUT))) begin
      lock_cnt_r <= 3'd0;
      o_locked   <= 1'b0;
      if (wd_r == 13'(TIMEOUT)) begin
        wd_r <= wd_r;
      end else begin
        wd_r <= wd_r + 13'd1;
      end
    end else begin
      wd_r <= wd_r + 13'd1;
    end
  end

endmodule

// File: tb/tb_fm_ddr_in_sync.sv
// Randomized stream bench for fm_ddr_in_sync: a stream-level model tags every input
// word from the embedded codes and predicts each output cycle five clocks later.
module tb_fm_ddr_in_sync;

  logic        clk_v = 1'b0;
  logic        rst_x;
  logic [7:0]  i_y;
  logic [7:0]  i_c;
  logic [7:0]  o_y;
  logic [7:0]  o_c;
  logic        o_de;
  logic        o_hs;
  logic        o_vs;
  logic        o_field;
  logic [11:0] o_pix_cnt;
  logic [10:0] o_line_cnt;
  logic        o_err;
  logic        o_locked;

  fm_ddr_in_sync dut (
    .clk_v      (clk_v),
    .rst_x      (rst_x),
    .i_y        (i_y),
    .i_c        (i_c),
    .o_y        (o_y),
    .o_c        (o_c),
    .o_de       (o_de),
    .o_hs       (o_hs),
    .o_vs       (o_vs),
    .o_field    (o_field),
    .o_pix_cnt  (o_pix_cnt),
    .o_line_cnt (o_line_cnt),
    .o_err      (o_err),
    .o_locked   (o_locked)
  );

  always #5 clk_v = ~clk_v;

  int n_run  = 0;
  int n_fail = 0;
  int de_seen;
  int err_seen;

  // Stream model: one entry per word pushed since the last reset.
  logic [7:0] qy[$];
  logic [7:0] qc[$];
  bit         qde[$];
  bit         qh[$];
  bit         qerr[$];
  bit         qcode[$];
  bit         m_active, m_hblank, m_vs, m_field, m_prev_de;
  int         m_pix, m_line;

  // The eight legal XY words (F,V,H = 000 .. 111).
  function automatic bit is_valid_xy(input logic [7:0] xy);
    logic [7:0] tbl [8] = '{8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1};
    for (int i = 0; i < 8; i++) if (tbl[i] == xy) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_clear();
    qy.delete(); qc.delete(); qde.delete(); qh.delete(); qerr.delete(); qcode.delete();
    m_active = 0; m_hblank = 0; m_vs = 0; m_field = 0; m_prev_de = 0;
    m_pix = 0; m_line = 0;
  endfunction

  function automatic void model_push(input logic [7:0] y, input logic [7:0] c);
    int k;
    qy.push_back(y); qc.push_back(c);
    qde.push_back(m_active); qh.push_back(m_hblank);
    qerr.push_back(1'b0); qcode.push_back(1'b0);
    k = qy.size() - 1;
    if (k >= 3 && qy[k-3] == 8'hFF && qy[k-2] == 8'h00 && qy[k-1] == 8'h00 && y[7]) begin
      if (is_valid_xy(y)) begin
        for (int i = k - 3; i <= k; i++) begin
          qde[i] = 1'b0;
          if (y[4]) qh[i] = 1'b1;
        end
        qcode[k] = 1'b1;
        if (y[4]) begin
          m_active = 0; m_hblank = 1;
        end else begin
          m_hblank = 0;
          if (!y[5]) m_active = 1;
        end
      end else begin
        qerr[k-3] = 1'b1;
      end
    end
  endfunction

  function automatic logic [7:0] rnd_pix();
    return 8'($urandom_range(254, 1));
  endfunction

  // Drive one word and compare the output cycle belonging to the word pushed 5 earlier.
  task automatic step(input logic [7:0] y, input logic [7:0] c);
    int s;
    logic [43:0] got, exp;
    @(posedge clk_v); #1;
    i_y = y; i_c = c;
    model_push(y, c);
    @(negedge clk_v);
    s = qy.size() - 6;
    if (s < 0) begin
      exp = 44'd0;
    end else begin
      if (qde[s]) m_pix = m_prev_de ? ((m_pix < 4095) ? m_pix + 1 : 4095) : 0;
      m_prev_de = qde[s];
      if (qcode[s]) begin
        if (qy[s][4]) m_line = (!qy[s][5] && m_vs) ? 0 : (m_line + 1) % 2048;
        m_vs    = qy[s][5];
        m_field = qy[s][6];
      end
      exp = {qy[s], qc[s], qde[s], qh[s], m_vs, m_field, 12'(m_pix), 11'(m_line), qerr[s]};
    end
    got = {o_y, o_c, o_de, o_hs, o_vs, o_field, o_pix_cnt, o_line_cnt, o_err};
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL stream slot=%0d got y=%h c=%h de=%b hs=%b vs=%b fld=%b pix=%0d line=%0d err=%b want y=%h c=%h de=%b hs=%b vs=%b fld=%b pix=%0d line=%0d err=%b",
               s, got[43:36], got[35:28], got[27], got[26], got[25], got[24], got[23:12], got[11:1], got[0],
               exp[43:36], exp[35:28], exp[27], exp[26], exp[25], exp[24], exp[23:12], exp[11:1], exp[0]);
    end
    if (o_de === 1'b1) de_seen++;
    if (o_err === 1'b1) err_seen++;
  endtask

  task automatic trs(input logic [7:0] xy);
    step(8'hFF, 8'($urandom)); step(8'h00, 8'($urandom));
    step(8'h00, 8'($urandom)); step(xy, 8'($urandom));
  endtask

  task automatic send_line(input logic [7:0] sav, input logic [7:0] eav, input int npix, input int nblank);
    trs(sav);
    for (int i = 0; i < npix; i++) step(rnd_pix(), 8'($urandom));
    trs(eav);
    for (int i = 0; i < nblank; i++) step(rnd_pix(), 8'($urandom));
  endtask

  task automatic check_zero_outputs(input string name);
    n_run++;
    if ({o_y, o_c, o_de, o_hs, o_vs, o_field, o_pix_cnt, o_line_cnt, o_err, o_locked} !== 45'd0) begin
      n_fail++;
      $display("FAIL %s outputs not zero in reset: y=%h c=%h de=%b hs=%b vs=%b pix=%0d line=%0d locked=%b want all 0",
               name, o_y, o_c, o_de, o_hs, o_vs, o_pix_cnt, o_line_cnt, o_locked);
    end
  endtask

  task automatic apply_reset(input string name);
    @(negedge clk_v);
    rst_x = 1'b0; i_y = 8'h00; i_c = 8'h00;
    #1;
    check_zero_outputs(name);
    repeat (2) @(negedge clk_v);
    rst_x = 1'b1;
    model_clear();
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_run++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    #2;
    check_zero_outputs("reset_initial");
    @(negedge clk_v);
    rst_x = 1'b1;
    model_clear();
    repeat (6) step(rnd_pix(), 8'($urandom));
    trs(8'h80);
    repeat (10) step(rnd_pix(), 8'($urandom));
    apply_reset("reset_mid_line");
    de_seen = 0;
    repeat (12) step(rnd_pix(), 8'($urandom));
    check_int("reset_no_de_before_sav", de_seen, 0);
    send_line(8'h80, 8'h9D, 6, 6);
  endtask

  task automatic test_single_line();
    de_seen = 0;
    trs(8'h80);
    for (int i = 0; i < 8; i++) step(8'h10 + 8'(i), 8'($urandom));
    trs(8'h9D);
    repeat (8) step(rnd_pix(), 8'($urandom));
    check_int("single_line_de_cycles", de_seen, 8);
  endtask

  task automatic test_field();
    for (int i = 0; i < 3; i++) send_line(8'hAB, 8'hB6, $urandom_range(12, 4), 6);
    send_line(8'hAB, 8'h9D, 8, 6);
    check_int("field_line_restart", int'(o_line_cnt), 0);
    check_bit("field_vs_low", o_vs, 1'b0);
    send_line(8'hC7, 8'hDA, $urandom_range(20, 5), 6);
    check_bit("field_f_bit", o_field, 1'b1);
    send_line(8'hEC, 8'hF1, 5, 6);
    check_bit("field_vs_f1", o_vs, 1'b1);
  endtask

  task automatic test_blank_line();
    de_seen = 0;
    send_line(8'hAB, 8'hB6, 12, 6);
    check_int("blank_line_no_de", de_seen, 0);
  endtask

  task automatic test_lock();
    apply_reset("reset_before_lock");
    for (int i = 0; i < 3; i++) send_line(8'h80, 8'h9D, $urandom_range(40, 8), 6);
    check_bit("lock_after_3", o_locked, 1'b0);
    send_line(8'h80, 8'h9D, $urandom_range(40, 8), 6);
    check_bit("lock_after_4", o_locked, 1'b1);
  endtask

  task automatic test_prot_err();
    err_seen = 0;
    trs(8'h80);
    repeat (5) step(rnd_pix(), 8'($urandom));
    trs(8'h81);
    repeat (5) step(rnd_pix(), 8'($urandom));
    trs(8'h9D);
    repeat (6) step(rnd_pix(), 8'($urandom));
    check_int("prot_err_pulses", err_seen, 1);
    check_bit("prot_err_unlock", o_locked, 1'b0);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4; i++) send_line(8'h80, 8'h9D, $urandom_range(32, 8), 6);
    check_bit("relock", o_locked, 1'b1);
    trs(8'h80);
    repeat (4292) step(rnd_pix(), 8'($urandom));
    check_bit("timeout_still_locked", o_locked, 1'b1);
    repeat (158) step(rnd_pix(), 8'($urandom));
    check_bit("timeout_unlock", o_locked, 1'b0);
    check_int("pix_saturate", int'(o_pix_cnt), 4095);
    trs(8'h9D);
    repeat (6) step(rnd_pix(), 8'($urandom));
  endtask

  initial begin
    rst_x = 1'b0;
    i_y   = 8'h00;
    i_c   = 8'h00;
    de_seen  = 0;
    err_seen = 0;
    model_clear();
    test_reset();
    test_single_line();
    test_field();
    test_blank_line();
    test_lock();
    test_prot_err();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fm_ddr_in_sync.md
Name: fm_ddr_in_sync

Overview:
- Receive-side counterpart of the HDMI DDR video output path.
- Takes the 8-bit Y and 8-bit C words already demultiplexed from the DDR input pins, one Y/C pair per clk_v cycle.
- Decodes embedded timing reference codes (TRS: FF 00 00 XY) on the Y channel and regenerates o_de/o_hs/o_vs/field plus pixel and line counters.
- Feeds the capture/scaler logic with aligned pixels and a lock indicator.

Parameters:
- LOCK_LINES, 4: consecutive error-free EAVs required to assert o_locked.
- TIMEOUT, 4400: max clk_v cycles between valid EAVs before lock is dropped; counter is 13 bits.

Ports:
- clk_v  in  1  video clock.
- rst_x  in  1  asynchronous active-low reset.
- i_y  in  8  luma word; carries the TRS.
- i_c  in  8  chroma word (Cb/Cr interleaved).
- o_y  out  8  aligned luma.
- o_c  out  8  aligned chroma.
- o_de  out  1  active pixel.
- o_hs  out  1  horizontal blanking, including both TRS sequences.
- o_vs  out  1  V bit of the last valid TRS.
- o_field  out  1  F bit of the last valid TRS.
- o_pix_cnt  out  12  index of the current active pixel.
- o_line_cnt  out  11  line index within the field.
- o_err  out  1  one-cycle pulse on a TRS protection error.
- o_locked  out  1  stable embedded sync.

Behaviour:
- Reset: all outputs and internal registers are 0, asynchronously, whenever rst_x=0.
- Pipeline:
  - Four stages s0..s3 on both Y and C; s0 is newest.
  - Each stage carries a de-tag and an h-tag.
  - o_y/o_c/o_de/o_hs register from s3, so a word on i_y at cycle n appears on o_y at n+5.
- Detection: combinational when s3=FF, s2=00, s1=00, and s0 bit7=1. XY bits are F=6, V=5, H=4 (1=EAV, 0=SAV).
- Protection check:
  - Expected values: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H (bits 3..0).
  - On mismatch: o_err=1 for one cycle, the code is ignored, and the words pass through with their existing tags.
- Internal flags:
  - active: set on valid SAV with V=0; cleared on any valid EAV.
  - hblank: set on EAV, cleared on SAV.
  - Both update at the detection edge.
- Tagging:
  - The word entering s0 takes de-tag=active and h-tag=hblank.
  - On any valid TRS detection, the four TRS words (moving to out/s3/s2/s1) get de-tag 0.
  - On EAV they also get h-tag 1.
  - Net effect: TRS words never have o_de=1; o_hs covers EAV TRS through SAV TRS inclusive.
- o_vs/o_field: load V/F from a valid code exactly when that code's XY word is on o_y, i.e. 4 cycles after detection.
- o_pix_cnt:
  - Is 0 on the first o_de cycle of a line.
  - Increments on each subsequent o_de cycle and holds when o_de=0.
  - Saturates at 4095.
- o_line_cnt:
  - Increments on the cycle the EAV XY word is on o_y.
  - Resets to 0 instead when that EAV has V=0 and the previous valid code had V=1 (start of active field).
  - Wraps at 2047.
- Lock:
  - A 3-bit lock counter increments on each valid EAV, saturates at LOCK_LINES, and sets o_locked on reaching it.
  - A watchdog counter resets on each valid EAV and increments otherwise.
  - Any protection error, or the watchdog reaching TIMEOUT, clears o_locked and the lock counter. The watchdog then holds at TIMEOUT until the next valid EAV.
- Simultaneous events: the pattern cannot overlap itself (FF followed by 00 00). A new TRS whose FF sits in s0 while a previous XY is in s0 is impossible, so no priority rule is needed.
- Data flow while unlocked: pixels still flow; o_de follows the flags regardless of o_locked.

Test Plan:
- Reset mid-line: assert rst_x low during active video. All outputs are 0 immediately. After release, o_de stays 0 until the next valid SAV.
- Single line: feed SAV (XY=80), 8 pixels Y=10..17, then EAV (XY=9D).
  - o_de high for exactly 8 cycles starting 5 cycles after the first pixel enters.
  - o_y=10..17; o_pix_cnt=0..7.
  - o_hs low only during those 8 cycles.
- Protection error: feed FF 00 00 81.
  - o_err pulses for one cycle.
  - Flags unchanged.
  - o_locked drops if it was set.
- Lock:
  - 4 lines each with a valid EAV, spacing below 4400 → o_locked=1 after the 4th EAV.
  - Then no TRS for 4400 cycles → o_locked=0.
- Field/vertical:
  - EAVs with V=1 (B6), then V=0 (9D) → o_line_cnt resets to 0 on the first V=0 EAV.
  - o_vs falls when that XY word is on o_y.
  - F=1 codes (F1/DA) → o_field=1.
- Blanking lines: SAV with V=1 (AB) followed by data → o_de stays 0, while o_hs and the counters behave normally.
